// File: rtl/host_mem_port_pkg.sv
// Shared definitions for the host memory port: data memory geometry and
// the engine's FSM state encoding.
package host_mem_port_pkg;

    localparam int DMEM_ADDR_W = 8;
    localparam int DMEM_DATA_W = 64;
    localparam int DMEM_DEPTH  = 256;

    // IDLE is encoded as zero so the debug state output reads 0 in reset.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_FLUSH = 2'd3
    } hmp_state_t;

endpackage

// File: rtl/host_rd_skid_fifo.sv
// Two-entry skid FIFO that absorbs read-port data while the host applies
// backpressure. Occupancy is exported so the issue logic can limit the
// number of reads in flight.
module host_rd_skid_fifo
    import host_mem_port_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_head,
    output logic [1:0]        o_count
);

    logic [DATA_W-1:0] r_mem [2];
    logic              r_rd_ptr;
    logic              r_wr_ptr;
    logic [1:0]        r_count;
    logic              w_do_push;
    logic              w_do_pop;

    // A pop frees its slot in the same cycle, so a full FIFO may still
    // accept a push when the head is leaving.
    assign w_do_pop  = i_pop && (r_count != 2'd0);
    assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

    // Storage, pointers and occupancy; simultaneous push/pop keeps the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/host_mem_port.sv
// Host-side engine for the data memory: converts host write bursts into
// memory word writes and host read bursts into pipelined reads on port B,
// streaming results back through a skid FIFO with valid/ready flow control.
//
// Handshakes: every channel transfers on a cycle where valid and ready are
// both high at the rising edge; valid never waits on ready, and once the
// engine raises a ready it does not depend on the matching valid.
module host_mem_port
    import host_mem_port_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W,
    parameter int LEN_W  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              gpu_busy,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_last,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              done,
    output logic              collision,
    output logic [1:0]        o_dbg_state
);

    hmp_state_t        r_state;
    hmp_state_t        w_next_state;
    logic              r_run;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [LEN_W-1:0]  r_remaining;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_inflight;
    logic              r_done;
    logic              r_collision;
    logic              r_busy_d;

    logic              w_cmd_fire;
    logic              w_wbeat;
    logic              w_rd_issue;
    logic              w_pop;
    logic              w_last_beat;
    logic              w_rem_one;
    logic              w_fifo_valid;
    logic [DATA_W-1:0] w_fifo_head;
    logic [1:0]        w_fifo_count;
    logic [2:0]        w_slots_used;

    assign w_cmd_fire = cmd_valid & cmd_ready;
    assign w_wbeat    = wdata_valid & wdata_ready;
    assign w_pop      = w_fifo_valid & rdata_ready;
    assign w_rem_one  = (r_remaining == LEN_W'(1));

    // Slots committed after this cycle's pop: reads are only issued when the
    // returning word is guaranteed a FIFO entry, which still allows one beat
    // per cycle when the host keeps up.
    assign w_slots_used = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    // The final beat is the only word left once issue has finished.
    assign w_last_beat = (r_state == ST_FLUSH) && (w_fifo_count == 2'd1) && !r_inflight;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus the handshake readies and read-issue strobe.
    always_comb begin
        w_next_state = r_state;
        cmd_ready    = 1'b0;
        wdata_ready  = 1'b0;
        w_rd_issue   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // r_run holds cmd_ready low while reset is asserted.
                cmd_ready = r_run & ~gpu_busy;
                if (cmd_valid && cmd_ready && (cmd_len != '0)) begin
                    w_next_state = cmd_write ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                wdata_ready = (r_remaining != '0);
                if (wdata_valid && wdata_ready && w_rem_one) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_READ: begin
                w_rd_issue = (r_remaining != '0) && (w_slots_used < 3'd2);
                if (w_rd_issue && w_rem_one) begin
                    w_next_state = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (w_pop && w_last_beat) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Burst address/length tracking, registered write port, completion and collision flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run       <= 1'b0;
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_inflight  <= 1'b0;
            r_done      <= 1'b0;
            r_collision <= 1'b0;
            r_busy_d    <= 1'b0;
        end else begin
            r_run      <= 1'b1;
            r_busy_d   <= gpu_busy;
            r_done     <= 1'b0;
            r_wr_en    <= 1'b0;
            r_inflight <= w_rd_issue;
            if (w_cmd_fire) begin
                r_cur_addr  <= cmd_addr;
                r_remaining <= cmd_len;
                r_collision <= 1'b0;
                r_done      <= (cmd_len == '0);
            end else if (gpu_busy && !r_busy_d && (r_state != ST_IDLE)) begin
                r_collision <= 1'b1;
            end
            if (w_wbeat) begin
                r_wr_en     <= 1'b1;
                r_wr_addr   <= r_cur_addr;
                r_wr_data   <= wdata;
                r_cur_addr  <= r_cur_addr + ADDR_W'(1);
                r_remaining <= r_remaining - LEN_W'(1);
                r_done      <= w_rem_one;
            end
            if (w_rd_issue) begin
                r_cur_addr  <= r_cur_addr + ADDR_W'(1);
                r_remaining <= r_remaining - LEN_W'(1);
            end
        end
    end

    host_rd_skid_fifo #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (r_inflight),
        .i_push_data (mem_rd_data),
        .i_pop       (w_pop),
        .o_valid     (w_fifo_valid),
        .o_head      (w_fifo_head),
        .o_count     (w_fifo_count)
    );

    assign mem_wr_en   = r_wr_en;
    assign mem_wr_addr = r_wr_addr;
    assign mem_wr_data = r_wr_data;
    assign mem_rd_en   = w_rd_issue;
    assign mem_rd_addr = w_rd_issue ? r_cur_addr : '0;
    assign rdata_valid = w_fifo_valid;
    assign rdata       = w_fifo_head;
    assign rdata_last  = w_fifo_valid & w_last_beat;
    assign done        = r_done | (w_pop & w_last_beat);
    assign collision   = r_collision;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_host_mem_port.sv
// Self-checking bench for host_mem_port: directed bursts plus randomized
// commands against a word-array reference of the memory, with a scoreboard
// monitor that pops expected write and read beats as the DUT presents them.
module tb_host_mem_port;

    localparam int AW = 8;
    localparam int DW = 64;
    localparam int LW = 9;

    logic          clk;
    logic          rst_n;
    logic          gpu_busy;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          wdata_valid;
    logic          wdata_ready;
    logic [DW-1:0] wdata;
    logic          rdata_valid;
    logic          rdata_ready = 1'b0;
    logic [DW-1:0] rdata;
    logic          rdata_last;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic          done;
    logic          collision;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;

    // Scoreboard queues: writes {last, addr, data}, reads {last, data}.
    logic [AW+DW:0] exp_wr_q[$];
    logic [DW:0]    exp_rd_q[$];

    logic [DW-1:0] env_mem [256];
    logic [DW-1:0] ref_mem [256];

    int cyc = 0;
    int done_cnt = 0;
    int exp_done = 0;
    int issued = 0;
    int delivered = 0;
    int wr_cnt = 0;
    int rr_mode = 0;
    int rr_phase = 0;
    bit await_first = 0;
    int first_cyc = 0;
    int accept_cyc = 0;

    logic [AW+DW:0] mw_e;
    logic [DW:0]    mr_e;

    host_mem_port dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .gpu_busy    (gpu_busy),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .wdata       (wdata),
        .rdata_valid (rdata_valid),
        .rdata_ready (rdata_ready),
        .rdata       (rdata),
        .rdata_last  (rdata_last),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .done        (done),
        .collision   (collision),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- memory environment (port B has 1-cycle latency) ----------------
    always @(posedge clk) begin
        if (mem_wr_en) env_mem[mem_wr_addr] <= mem_wr_data;
        if (mem_rd_en) mem_rd_data <= env_mem[mem_rd_addr];
    end

    // Host read-ready pattern, changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        rr_phase++;
        case (rr_mode)
            0:       rdata_ready = 1'b1;
            1:       rdata_ready = ((rr_phase % 3) == 0);
            2:       rdata_ready = 1'($urandom_range(0, 1));
            default: rdata_ready = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (mem_wr_en) wr_cnt++;
            if (mem_rd_en) issued++;
            if (rdata_valid && rdata_ready) delivered++;
            if (mem_rd_en) check("rd_outstanding_le2", 128'(issued - delivered <= 2), 128'd1);
            if (await_first && rdata_valid) begin
                first_cyc   = cyc;
                await_first = 0;
            end
            if (mem_wr_en) begin
                if (exp_wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_unexpected: got addr %0h data %0h expected no write", mem_wr_addr, mem_wr_data);
                end else begin
                    mw_e = exp_wr_q.pop_front();
                    check("wr_addr", 128'(mem_wr_addr), 128'(mw_e[AW+DW-1:DW]));
                    check("wr_data", 128'(mem_wr_data), 128'(mw_e[DW-1:0]));
                    check("wr_done", 128'(done), 128'(mw_e[AW+DW]));
                end
            end
            if (rdata_valid && rdata_ready) begin
                if (exp_rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: got data %0h expected no beat", rdata);
                end else begin
                    mr_e = exp_rd_q.pop_front();
                    check("rd_data", 128'(rdata), 128'(mr_e[DW-1:0]));
                    check("rd_last", 128'(rdata_last), 128'(mr_e[DW]));
                    check("rd_done", 128'(done), 128'(mr_e[DW]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input bit wr, input logic [7:0] a, input int len, output bit ok);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_len   = LW'(len);
        ok = 0;
        for (int t = 0; t < 200; t++) begin
            if (cmd_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        check("cmd_accept", 128'(ok), 128'd1);
        @(negedge clk);
        cmd_valid  = 1'b0;
        accept_cyc = cyc;
    endtask

    task automatic wait_done();
        int t;
        for (t = 0; t < 3000; t++) begin
            if (done_cnt == exp_done) break;
            @(negedge clk);
        end
        @(negedge clk);
        check("done_count", 128'(done_cnt), 128'(exp_done));
    endtask

    task automatic write_burst(input logic [7:0] a, input int len, input int collide_at,
                               input bit rnd, input logic [DW-1:0] base);
        bit ok;
        int i;
        int guard;
        logic [7:0] a8;
        send_cmd(1'b1, a, len, ok);
        if (ok) exp_done++;
        i = 0;
        guard = 0;
        while (i < len && guard < 3000) begin
            wdata_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            wdata       = rnd ? {$urandom, $urandom} : base + DW'(i);
            if (i == collide_at) gpu_busy = 1'b1;
            if (wdata_valid && wdata_ready) begin
                a8 = a + 8'(i);
                ref_mem[a8] = wdata;
                exp_wr_q.push_back({(i == len - 1), a8, wdata});
                i++;
            end
            guard++;
            @(negedge clk);
        end
        wdata_valid = 1'b0;
        check("wr_beats_sent", 128'(i), 128'(len));
        wait_done();
    endtask

    task automatic push_read_exp(input logic [7:0] a, input int len);
        logic [7:0] a8;
        for (int i = 0; i < len; i++) begin
            a8 = a + 8'(i);
            exp_rd_q.push_back({(i == len - 1), ref_mem[a8]});
        end
    endtask

    task automatic read_burst(input logic [7:0] a, input int len, input bit chk_lat);
        bit ok;
        int iss0;
        iss0 = issued;
        await_first = 1;
        send_cmd(1'b0, a, len, ok);
        if (ok) exp_done++;
        push_read_exp(a, len);
        wait_done();
        check("rd_issue_count", 128'(issued - iss0), 128'(len));
        check("rd_queue_drained", 128'(exp_rd_q.size()), 128'd0);
        if (chk_lat) check("rd_first_latency", 128'(first_cyc - accept_cyc), 128'd2);
    endtask

    task automatic zero_len(input bit wr, input logic [7:0] a);
        bit ok;
        int w0;
        int i0;
        w0 = wr_cnt;
        i0 = issued;
        send_cmd(wr, a, 0, ok);
        if (ok) exp_done++;
        check("len0_done", 128'(done), 128'd1);
        @(negedge clk);
        check("len0_done_pulse", 128'(done), 128'd0);
        repeat (3) @(negedge clk);
        check("len0_no_traffic", {64'(wr_cnt - w0), 64'(issued - i0)}, 128'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl"}, 128'({cmd_ready, wdata_ready, rdata_valid, rdata_last, mem_wr_en,
                                    mem_rd_en, done, collision, dbg_state}), 128'd0);
        check({tag, "_addr"}, 128'({mem_wr_addr, mem_rd_addr}), 128'd0);
        check({tag, "_rdata"}, 128'(rdata), 128'd0);
        check({tag, "_wdata"}, 128'(mem_wr_data), 128'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit ok;
        bit seen_ready;
        int w0;
        int i0;
        rst_n       = 1'b0;
        gpu_busy    = 1'b0;
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_addr    = '0;
        cmd_len     = '0;
        wdata_valid = 1'b0;
        wdata       = '0;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = {$urandom, $urandom};
            env_mem[i] = ref_mem[i];
        end
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single-word write with a fixed pattern.
        write_burst(8'h10, 1, -1, 1'b0, 64'h0004_0003_0002_0001);

        // Pre-load 0x20..0x23, then stream them back with ready held high.
        write_burst(8'h20, 4, -1, 1'b0, 64'hA5A5_0000_0000_0020);
        rr_mode = 0;
        read_burst(8'h20, 4, 1'b1);

        // Backpressure with ready pattern 1,0,0.
        rr_phase = 0;
        rr_mode  = 1;
        read_burst(8'h08, 8, 1'b0);

        // Address wrap on write, then read the wrapped range back.
        write_burst(8'hFE, 4, -1, 1'b1, '0);
        rr_mode = 2;
        read_burst(8'hFE, 4, 1'b0);

        // Commands are refused while the GPU runs.
        w0 = wr_cnt;
        i0 = issued;
        seen_ready = 0;
        @(negedge clk);
        gpu_busy  = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_len   = LW'(3);
        repeat (8) begin
            @(negedge clk);
            if (cmd_ready) seen_ready = 1;
        end
        cmd_valid = 1'b0;
        gpu_busy  = 1'b0;
        check("busy_gates_ready", 128'(seen_ready), 128'd0);
        check("busy_no_traffic", {64'(wr_cnt - w0), 64'(issued - i0)}, 128'd0);

        // Zero-length commands.
        zero_len(1'b1, 8'h30);
        zero_len(1'b0, 8'h31);

        // GPU starts mid-write: burst completes and collision sticks.
        write_burst(8'h40, 6, 2, 1'b1, '0);
        check("collision_set", 128'(collision), 128'd1);
        @(negedge clk);
        gpu_busy = 1'b0;
        check("collision_held", 128'(collision), 128'd1);
        zero_len(1'b1, 8'h41);
        check("collision_cleared", 128'(collision), 128'd0);
        rr_mode = 0;
        read_burst(8'h40, 6, 1'b1);

        // Full-depth read.
        read_burst(8'h33, 256, 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            logic [7:0] ra;
            int rl;
            ra = 8'($urandom);
            rl = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
            rr_mode = 2;
            if (rl == 0) zero_len(1'($urandom_range(0, 1)), ra);
            else if ($urandom_range(0, 1) == 1) write_burst(ra, rl, -1, 1'b1, '0);
            else read_burst(ra, rl, 1'b0);
        end

        // Reset in the middle of a stalled read.
        rr_mode = 3;
        send_cmd(1'b0, 8'h80, 8, ok);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        exp_rd_q.delete();
        issued    = 0;
        delivered = 0;
        w0 = wr_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset_state", 128'(dbg_state), 128'd0);
        check("post_reset_ready", 128'(cmd_ready), 128'd1);
        check("post_reset_quiet", {64'(wr_cnt - w0), 64'(issued)}, 128'd0);
        rr_mode = 0;
        read_burst(8'h20, 4, 1'b1);

        repeat (3) @(negedge clk);
        check("final_wr_queue", 128'(exp_wr_q.size()), 128'd0);
        check("final_rd_queue", 128'(exp_rd_q.size()), 128'd0);
        check("final_done_total", 128'(done_cnt), 128'(exp_done));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
